// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_port_arbiter
//  Description : Single framebuffer RAM port shared between the display fetch
//                path and the automaton update engine. The RAM is split into
//                two banks. Display and engine reads use the front bank, and
//                engine writes use the back bank. Front and back swap at end
//                of frame, once the engine has finished a generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 20,
    parameter int STARVE_MAX = 64
) (
    input  logic          clk108,
    input  logic          reset_n,
    // display fetch path
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_valid,
    output logic [DW-1:0] disp_data,
    input  logic          frame_done,
    // automaton engine
    input  logic          eng_req,
    input  logic          eng_we,
    input  logic [AW-1:0] eng_addr,
    input  logic [DW-1:0] eng_wdata,
    output logic          eng_gnt,
    output logic          eng_rvalid,
    output logic [DW-1:0] eng_rdata,
    input  logic          eng_gen_done,
    output logic          eng_hold,
    output logic          eng_starve,
    // RAM port
    output logic [AW:0]   mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_q,
    // bank status
    output logic          front,
    output logic          swap,
    output logic [15:0]   gen_count
);

    // The counter must be able to hold STARVE_MAX itself, because that value
    // is the saturation point and the flag condition.
    localparam int             CW           = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  c_starve_max = CW'(STARVE_MAX);

    // RUN: engine may be granted. PEND: finished generation waits for the
    // end of frame before the banks are exchanged.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_front;
    logic            r_swap;
    logic            r_hold;
    logic [15:0]     r_gen_count;
    logic [CW-1:0]   r_starve_cnt;
    logic            r_disp_valid;
    logic            r_eng_rvalid;

    logic            w_eng_gnt;
    logic            w_run;

    assign w_run     = (r_state == ST_RUN);
    // Display has absolute priority; the engine is also locked out while a
    // swap is pending so the back bank stays stable until it becomes front.
    assign w_eng_gnt = !disp_req && eng_req && w_run;

    // Combinational port mux; the bank bit comes from the current front so
    // a granted access always targets the bank valid in its grant cycle.
    always_comb begin
        mem_addr  = {r_front, {AW{1'b0}}};
        mem_we    = 1'b0;
        mem_wdata = eng_wdata;
        if (disp_req) begin
            mem_addr = {r_front, disp_addr};
        end else if (w_eng_gnt) begin
            mem_addr = {(eng_we ? ~r_front : r_front), eng_addr};
            mem_we   = eng_we;
        end
    end

    // Read-return strobes: RAM data arrives one cycle after the address, so
    // the valids are the previous cycle's read grants.
    always_ff @(posedge clk108 or negedge reset_n) begin
        if (!reset_n) begin
            r_disp_valid <= 1'b0;
            r_eng_rvalid <= 1'b0;
        end else begin
            r_disp_valid <= disp_req;
            r_eng_rvalid <= w_eng_gnt && !eng_we;
        end
    end

    // Swap FSM: hold the engine off after a finished generation and flip the
    // banks on the next end of frame (immediately if both arrive together).
    always_ff @(posedge clk108 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_front     <= 1'b0;
            r_swap      <= 1'b0;
            r_hold      <= 1'b0;
            r_gen_count <= 16'd0;
        end else begin
            r_swap <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (eng_gen_done && frame_done) begin
                        r_front     <= ~r_front;
                        r_swap      <= 1'b1;
                        r_gen_count <= r_gen_count + 16'd1;
                    end else if (eng_gen_done) begin
                        r_state <= ST_PEND;
                        r_hold  <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (frame_done) begin
                        r_state     <= ST_RUN;
                        r_hold      <= 1'b0;
                        r_front     <= ~r_front;
                        r_swap      <= 1'b1;
                        r_gen_count <= r_gen_count + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    // Starvation monitor: counts consecutive denied requests while the
    // engine is allowed to run, saturating at the flag threshold.
    always_ff @(posedge clk108 or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (w_eng_gnt || !w_run) begin
            r_starve_cnt <= '0;
        end else if (eng_req && (r_starve_cnt != c_starve_max)) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
        end
    end

    assign eng_gnt    = w_eng_gnt;
    assign disp_valid = r_disp_valid;
    assign eng_rvalid = r_eng_rvalid;
    assign disp_data  = mem_q;
    assign eng_rdata  = mem_q;
    assign eng_hold   = r_hold;
    assign eng_starve = (r_starve_cnt == c_starve_max);
    assign front      = r_front;
    assign swap       = r_swap;
    assign gen_count  = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_port_arbiter
//  Description : Directed self-checking bench for fb_port_arbiter. The RAM
//                model returns {3'b0,addr} ^ 20'hABCDB one cycle after the
//                address, so word 0x00005 reads back as 0xABCDE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 20;

    logic          clk108;
    logic          reset_n;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          frame_done;
    logic          eng_req;
    logic          eng_we;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_wdata;
    logic          eng_gnt;
    logic          eng_rvalid;
    logic [DW-1:0] eng_rdata;
    logic          eng_gen_done;
    logic          eng_hold;
    logic          eng_starve;
    logic [AW:0]   mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_q;
    logic          front;
    logic          swap;
    logic [15:0]   gen_count;

    logic [AW:0]   lw_addr;
    logic [DW-1:0] lw_data;

    int total = 0;
    int bad   = 0;

    fb_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(64)) dut (
        .clk108       (clk108),
        .reset_n      (reset_n),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_valid   (disp_valid),
        .disp_data    (disp_data),
        .frame_done   (frame_done),
        .eng_req      (eng_req),
        .eng_we       (eng_we),
        .eng_addr     (eng_addr),
        .eng_wdata    (eng_wdata),
        .eng_gnt      (eng_gnt),
        .eng_rvalid   (eng_rvalid),
        .eng_rdata    (eng_rdata),
        .eng_gen_done (eng_gen_done),
        .eng_hold     (eng_hold),
        .eng_starve   (eng_starve),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_q        (mem_q),
        .front        (front),
        .swap         (swap),
        .gen_count    (gen_count)
    );

    initial clk108 = 1'b0;
    always #5 clk108 = ~clk108;

    // RAM model: address-derived read data, last write captured for checking
    always @(posedge clk108) begin
        mem_q <= {3'b000, mem_addr} ^ 20'hABCDB;
        if (mem_we) begin
            lw_addr <= mem_addr;
            lw_data <= mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk108);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic gnt_seen;
    logic hold_lost;
    logic hold_seen;

    initial begin
        reset_n = 1'b0; disp_req = 1'b0; disp_addr = '0; frame_done = 1'b0;
        eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;
        eng_gen_done = 1'b0;
        tick(); tick();
        // reset state
        chk("rst_front",     {31'd0, front},      32'd0);
        chk("rst_swap",      {31'd0, swap},       32'd0);
        chk("rst_hold",      {31'd0, eng_hold},   32'd0);
        chk("rst_starve",    {31'd0, eng_starve}, 32'd0);
        chk("rst_gen_count", {16'd0, gen_count},  32'd0);
        chk("rst_dvalid",    {31'd0, disp_valid}, 32'd0);
        chk("rst_ervalid",   {31'd0, eng_rvalid}, 32'd0);
        chk("rst_mem_addr",  {15'd0, mem_addr},   32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},     32'd0);
        reset_n = 1'b1;
        tick();

        // 1: plain display read
        disp_req = 1'b1; disp_addr = 16'h0005; #1;
        chk("t1_mem_addr", {15'd0, mem_addr}, 32'h00005);
        chk("t1_mem_we",   {31'd0, mem_we},   32'd0);
        chk("t1_gnt",      {31'd0, eng_gnt},  32'd0);
        tick(); disp_req = 1'b0;
        chk("t1_dvalid",   {31'd0, disp_valid}, 32'd1);
        chk("t1_ddata",    {12'd0, disp_data},  32'hABCDE);
        chk("t1_ervalid",  {31'd0, eng_rvalid}, 32'd0);
        tick();
        chk("t1_dvalid_off", {31'd0, disp_valid}, 32'd0);

        // 2: display beats a simultaneous engine read
        disp_req = 1'b1; disp_addr = 16'h0020;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 16'h0010; #1;
        chk("t2_gnt_denied", {31'd0, eng_gnt},  32'd0);
        chk("t2_addr_disp",  {15'd0, mem_addr}, 32'h00020);
        tick(); disp_req = 1'b0; #1;
        chk("t2_gnt",        {31'd0, eng_gnt},    32'd1);
        chk("t2_addr_eng",   {15'd0, mem_addr},   32'h00010);
        chk("t2_dvalid",     {31'd0, disp_valid}, 32'd1);
        tick(); eng_req = 1'b0;
        chk("t2_ervalid",    {31'd0, eng_rvalid}, 32'd1);
        chk("t2_erdata",     {12'd0, eng_rdata},  32'hABCCB);
        chk("t2_dvalid_off", {31'd0, disp_valid}, 32'd0);
        tick();
        chk("t2_ervalid_off", {31'd0, eng_rvalid}, 32'd0);

        // 3: engine write goes to back bank, read to front bank
        eng_req = 1'b1; eng_we = 1'b1; eng_addr = 16'h0003; eng_wdata = 20'h12345; #1;
        chk("t3_wgnt",   {31'd0, eng_gnt},   32'd1);
        chk("t3_waddr",  {15'd0, mem_addr},  32'h10003);
        chk("t3_we",     {31'd0, mem_we},    32'd1);
        chk("t3_wdata",  {12'd0, mem_wdata}, 32'h12345);
        tick(); eng_we = 1'b0; #1;
        chk("t3_w_noret", {31'd0, eng_rvalid}, 32'd0);
        chk("t3_raddr",   {15'd0, mem_addr},   32'h00003);
        chk("t3_rwe",     {31'd0, mem_we},     32'd0);
        chk("t3_lw_addr", {15'd0, lw_addr},    32'h10003);
        chk("t3_lw_data", {12'd0, lw_data},    32'h12345);
        tick(); eng_req = 1'b0;
        chk("t3_ervalid", {31'd0, eng_rvalid}, 32'd1);
        chk("t3_erdata",  {12'd0, eng_rdata},  32'hABCD8);

        // 4: generation done, swap deferred to frame_done 100 cycles later
        eng_gen_done = 1'b1;
        tick(); eng_gen_done = 1'b0;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 16'h0007; #1;
        chk("t4_hold",      {31'd0, eng_hold}, 32'd1);
        chk("t4_gnt_block", {31'd0, eng_gnt},  32'd0);
        chk("t4_idle_addr", {15'd0, mem_addr}, 32'h00000);
        gnt_seen = 1'b0; hold_lost = 1'b0;
        for (int i = 0; i < 99; i++) begin
            tick();
            gnt_seen  = gnt_seen | eng_gnt;
            hold_lost = hold_lost | !eng_hold;
        end
        chk("t4_no_gnt",      {31'd0, gnt_seen},   32'd0);
        chk("t4_hold_steady", {31'd0, hold_lost},  32'd0);
        chk("t4_no_starve",   {31'd0, eng_starve}, 32'd0);
        chk("t4_no_swap_yet", {31'd0, swap},       32'd0);
        frame_done = 1'b1; #1;
        chk("t4_gnt_fd", {31'd0, eng_gnt}, 32'd0);
        tick(); frame_done = 1'b0; #1;
        chk("t4_swap",      {31'd0, swap},      32'd1);
        chk("t4_front",     {31'd0, front},     32'd1);
        chk("t4_gen_count", {16'd0, gen_count}, 32'd1);
        chk("t4_hold_clr",  {31'd0, eng_hold},  32'd0);
        chk("t4_gnt_back",  {31'd0, eng_gnt},   32'd1);
        chk("t4_eng_addr",  {15'd0, mem_addr},  32'h10007);
        tick(); eng_req = 1'b0;
        chk("t4_swap_pulse", {31'd0, swap}, 32'd0);
        disp_req = 1'b1; disp_addr = 16'h0009; #1;
        chk("t4_disp_addr", {15'd0, mem_addr}, 32'h10009);
        tick(); disp_req = 1'b0;
        chk("t4_ddata", {12'd0, disp_data}, 32'hBBCD2);

        // 5: simultaneous gen_done/frame_done swaps immediately; counter wraps
        eng_gen_done = 1'b1; frame_done = 1'b1;
        tick(); eng_gen_done = 1'b0; frame_done = 1'b0; #1;
        chk("t5_swap",      {31'd0, swap},      32'd1);
        chk("t5_front",     {31'd0, front},     32'd0);
        chk("t5_gen_count", {16'd0, gen_count}, 32'd2);
        chk("t5_no_hold",   {31'd0, eng_hold},  32'd0);
        hold_seen = 1'b0;
        eng_gen_done = 1'b1; frame_done = 1'b1;
        for (int i = 0; i < 65533; i++) begin
            tick();
            hold_seen = hold_seen | eng_hold;
        end
        eng_gen_done = 1'b0; frame_done = 1'b0;
        chk("t5_hold_never", {31'd0, hold_seen}, 32'd0);
        chk("t5_count_max",  {16'd0, gen_count}, 32'h0000FFFF);
        chk("t5_front_odd",  {31'd0, front},     32'd1);
        eng_gen_done = 1'b1; frame_done = 1'b1;
        tick(); eng_gen_done = 1'b0; frame_done = 1'b0;
        chk("t5_count_wrap", {16'd0, gen_count}, 32'd0);
        chk("t5_front_wrap", {31'd0, front},     32'd0);
        chk("t5_swap_wrap",  {31'd0, swap},      32'd1);

        // 6: starvation under continuous display traffic
        disp_req = 1'b1; disp_addr = 16'h0001;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 16'h0002;
        repeat (63) tick();
        chk("t6_starve_63", {31'd0, eng_starve}, 32'd0);
        tick();
        chk("t6_starve_64", {31'd0, eng_starve}, 32'd1);
        repeat (5) tick();
        chk("t6_starve_sat", {31'd0, eng_starve}, 32'd1);
        disp_req = 1'b0; #1;
        chk("t6_gnt", {31'd0, eng_gnt}, 32'd1);
        tick(); eng_req = 1'b0;
        chk("t6_starve_clr", {31'd0, eng_starve}, 32'd0);

        // reset in PEND with a display read in flight
        eng_gen_done = 1'b1; frame_done = 1'b1;
        tick(); eng_gen_done = 1'b0; frame_done = 1'b0;
        chk("t6_front_pre", {31'd0, front}, 32'd1);
        eng_gen_done = 1'b1;
        tick(); eng_gen_done = 1'b0;
        chk("t6_hold_pre", {31'd0, eng_hold}, 32'd1);
        disp_req = 1'b1; disp_addr = 16'h0004;
        tick(); disp_req = 1'b0;
        chk("t6_dvalid_pre", {31'd0, disp_valid}, 32'd1);
        reset_n = 1'b0; #1;
        chk("t6_rst_dvalid", {31'd0, disp_valid}, 32'd0);
        chk("t6_rst_front",  {31'd0, front},      32'd0);
        chk("t6_rst_hold",   {31'd0, eng_hold},   32'd0);
        chk("t6_rst_count",  {16'd0, gen_count},  32'd0);
        chk("t6_rst_swap",   {31'd0, swap},       32'd0);
        chk("t6_rst_starve", {31'd0, eng_starve}, 32'd0);
        chk("t6_rst_ervld",  {31'd0, eng_rvalid}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("t6_post_dvalid", {31'd0, disp_valid}, 32'd0);
        chk("t6_post_hold",   {31'd0, eng_hold},   32'd0);
        eng_req = 1'b1; #1;
        chk("t6_post_gnt",  {31'd0, eng_gnt},  32'd1);
        chk("t6_post_addr", {15'd0, mem_addr}, 32'h00002);
        tick(); eng_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
